// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access-port arbiter.
// The request struct is sized by DMEM_AWIDTH/DMEM_DWIDTH; keep these equal to the top's AWIDTH/DWIDTH.
package dmem_pkg;
  localparam int DMEM_AWIDTH = 12;
  localparam int DMEM_DWIDTH = 32;

  localparam logic [1:0] MODE_WORD = 2'b00;
  localparam logic [1:0] MODE_BYTE = 2'b01;
  localparam logic [1:0] MODE_HALF = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic                   we;
    logic [1:0]             mode;
    logic [DMEM_AWIDTH-1:0] addr;
    logic [DMEM_DWIDTH-1:0] wdata;
  } dmem_req_t;
endpackage

// File: rtl/dmem_align_chk.sv
// Flags illegal modes and misaligned word/half accesses.
module dmem_align_chk
  import dmem_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [1:0] addr_lo,
  output logic       err
);
  always_comb begin
    err = 1'b0;
    case (mode)
      MODE_WORD: err = |addr_lo;
      MODE_BYTE: err = 1'b0;
      MODE_HALF: err = addr_lo[0];
      default:   err = 1'b1;
    endcase
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the data memory main port: grant, access, registered response.
// DMEM_ARB_FIXED_PRIO_EN: m0 always wins ties (no round-robin state); undefined: round-robin.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AWIDTH = DMEM_AWIDTH,
  parameter int DWIDTH = DMEM_DWIDTH
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [1:0]        m0_mode,
  input  logic [AWIDTH-1:0] m0_addr,
  input  logic [DWIDTH-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DWIDTH-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [1:0]        m1_mode,
  input  logic [AWIDTH-1:0] m1_addr,
  input  logic [DWIDTH-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DWIDTH-1:0] m1_rdata,
  output logic              m1_err,
  output logic              mem_str,
  output logic [1:0]        mem_mode,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_din,
  input  logic [DWIDTH-1:0] mem_dout
);
  state_t            state, state_nxt;
  dmem_req_t         req_q, sel_req;
  logic              win, win_q, err_q, sel_err, any_req, take;
  logic [DWIDTH-1:0] rdata_q;

  assign any_req = m0_req | m1_req;
  assign take    = (state == IDLE) & any_req;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign win = ~m0_req;
`else
  logic last_q;
  // On a tie, hand the grant to whoever did not win last time.
  assign win = (m0_req & m1_req) ? ~last_q : m1_req;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)    last_q <= 1'b1;
    else if (take) last_q <= win;
  end
`endif

  assign sel_req = win ? '{we: m1_we, mode: m1_mode, addr: m1_addr, wdata: m1_wdata}
                       : '{we: m0_we, mode: m0_mode, addr: m0_addr, wdata: m0_wdata};

  dmem_align_chk u_align_chk (
    .mode    (sel_req.mode),
    .addr_lo (sel_req.addr[1:0]),
    .err     (sel_err)
  );

  // Gated by clr_n so grants vanish the instant reset is applied.
  assign m0_gnt = clr_n & take & ~win;
  assign m1_gnt = clr_n & take &  win;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= IDLE;
      req_q   <= '0;
      win_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        req_q <= sel_req;
        win_q <= win;
        err_q <= sel_err;
      end
      if (state == ACCESS) rdata_q <= (!req_q.we && !err_q) ? mem_dout : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_str   = 1'b0;
    mem_mode  = '0;
    mem_addr  = '0;
    mem_din   = '0;
    m0_rvalid = 1'b0;
    m0_rdata  = '0;
    m0_err    = 1'b0;
    m1_rvalid = 1'b0;
    m1_rdata  = '0;
    m1_err    = 1'b0;
    case (state)
      IDLE: if (any_req) state_nxt = ACCESS;
      ACCESS: begin
        state_nxt = RESP;
        mem_str   = req_q.we & ~err_q;
        mem_mode  = req_q.mode;
        mem_addr  = req_q.addr;
        mem_din   = req_q.wdata;
      end
      RESP: begin
        state_nxt = IDLE;
        if (win_q) begin
          m1_rvalid = 1'b1;
          m1_rdata  = rdata_q;
          m1_err    = err_q;
        end else begin
          m0_rvalid = 1'b1;
          m0_rdata  = rdata_q;
          m0_err    = err_q;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: byte-lane memory model plus a response scoreboard.
module tb_dmem_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          clr_n;
  logic          m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
  logic [1:0]    m0_mode;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
  logic [1:0]    m1_mode;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          mem_str;
  logic [1:0]    mem_mode;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;

  int errors = 0;
  int checks = 0;
  int str_cnt = 0;

  typedef struct {
    logic          id;
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;
  exp_t sb[$];

  logic [7:0] mem [0:4095];

  always #5 clk = ~clk;

  dmem_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk(clk), .clr_n(clr_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_mode(m0_mode), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_mode(m1_mode), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_str(mem_str), .mem_mode(mem_mode), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  // Little-endian byte memory that does its own lane shifting.
  always @(posedge clk) begin
    if (mem_str) begin
      str_cnt++;
      case (mem_mode)
        2'b01: mem[mem_addr] <= mem_din[7:0];
        2'b10: begin
          mem[{mem_addr[11:1], 1'b0}] <= mem_din[7:0];
          mem[{mem_addr[11:1], 1'b1}] <= mem_din[15:8];
        end
        default: begin
          mem[{mem_addr[11:2], 2'b00}] <= mem_din[7:0];
          mem[{mem_addr[11:2], 2'b01}] <= mem_din[15:8];
          mem[{mem_addr[11:2], 2'b10}] <= mem_din[23:16];
          mem[{mem_addr[11:2], 2'b11}] <= mem_din[31:24];
        end
      endcase
    end
  end

  always_comb begin
    case (mem_mode)
      2'b01:   mem_dout = {24'h0, mem[mem_addr]};
      2'b10:   mem_dout = {16'h0, mem[{mem_addr[11:1], 1'b1}], mem[{mem_addr[11:1], 1'b0}]};
      default: mem_dout = {mem[{mem_addr[11:2], 2'b11}], mem[{mem_addr[11:2], 2'b10}],
                           mem[{mem_addr[11:2], 2'b01}], mem[{mem_addr[11:2], 2'b00}]};
    endcase
  end

  // Response monitor: every rvalid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (m0_rvalid || m1_rvalid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected m0_rvalid=%b m1_rvalid=%b, required no response", m0_rvalid, m1_rvalid);
      end else begin
        e = sb.pop_front();
        if ({m1_rvalid, m0_rvalid} !== (e.id ? 2'b10 : 2'b01) ||
            (e.id ? m1_err : m0_err) !== e.err ||
            (e.id ? m1_rdata : m0_rdata) !== e.rdata) begin
          errors++;
          $display("FAIL sb_resp got rvalid=%b%b err0=%b err1=%b rdata0=%h rdata1=%h, required id=%0d err=%b rdata=%h",
                   m1_rvalid, m0_rvalid, m0_err, m1_err, m0_rdata, m1_rdata, e.id, e.err, e.rdata);
        end
      end
    end
  end

  task automatic drive(input logic id, input logic req, input logic we, input logic [1:0] mode,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (id) begin m1_req = req; m1_we = we; m1_mode = mode; m1_addr = addr; m1_wdata = wdata; end
    else    begin m0_req = req; m0_we = we; m0_mode = mode; m0_addr = addr; m0_wdata = wdata; end
  endtask

  // Single transaction with grant / access / response timing checks.
  task automatic issue(input logic id, input logic we, input logic [1:0] mode, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic exp_err, input logic [DW-1:0] exp_rdata);
    int n;
    @(negedge clk);
    drive(id, 1'b1, we, mode, addr, wdata);
    #1;
    n = 0;
    while ((id ? m1_gnt : m0_gnt) !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL gnt_timeout id=%0d no grant seen, required grant within 20 cycles", id);
      drive(id, 1'b0, 1'b0, 2'b00, '0, '0);
    end else begin
      sb.push_back('{id, exp_err, exp_rdata});
      @(posedge clk); #1;
      drive(id, 1'b0, 1'b0, 2'b00, '0, '0);
      @(negedge clk);
      checks++;
      if (mem_str !== (we & ~exp_err)) begin
        errors++;
        $display("FAIL access_str id=%0d mem_str=%b, required %b", id, mem_str, we & ~exp_err);
      end
      checks++;
      if (mem_addr !== addr || mem_mode !== mode || mem_din !== wdata) begin
        errors++;
        $display("FAIL access_bus addr=%h mode=%b din=%h, required addr=%h mode=%b din=%h",
                 mem_addr, mem_mode, mem_din, addr, mode, wdata);
      end
      @(negedge clk);
      checks++;
      if ((id ? m1_rvalid : m0_rvalid) !== 1'b1) begin
        errors++;
        $display("FAIL resp_latency id=%0d rvalid=%b at T+2, required 1", id, id ? m1_rvalid : m0_rvalid);
      end
    end
  endtask

  task automatic test_reset;
    clr_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 2'b00, 12'h010, '0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, '0, '0);
    repeat (2) @(negedge clk);
    checks++;
    if ({m0_gnt, m0_rvalid, m0_rdata, m0_err, m1_gnt, m1_rvalid, m1_rdata, m1_err,
         mem_str, mem_mode, mem_addr, mem_din} !== '0) begin
      errors++;
      $display("FAIL reset_outputs gnt=%b%b str=%b addr=%h, required all zero", m1_gnt, m0_gnt, mem_str, mem_addr);
    end
    m0_req = 1'b0;
    clr_n  = 1'b1;
  endtask

  task automatic test_store_load;
    issue(1'b0, 1'b1, 2'b00, 12'h010, 32'hDEADBEEF, 1'b0, 32'h0);
    issue(1'b0, 1'b0, 2'b00, 12'h010, 32'h0, 1'b0, 32'hDEADBEEF);
    issue(1'b1, 1'b1, 2'b01, 12'h013, 32'h000000AB, 1'b0, 32'h0);
    issue(1'b1, 1'b0, 2'b00, 12'h010, 32'h0, 1'b0, 32'hABADBEEF);
    issue(1'b1, 1'b0, 2'b10, 12'h012, 32'h0, 1'b0, 32'h0000ABAD);
  endtask

  task automatic test_back_to_back;
    int   grants, cyc;
    logic exp_win;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 2'b00, 12'h010, '0);
    drive(1'b1, 1'b1, 1'b0, 2'b00, 12'h010, '0);
    grants = 0;
    cyc    = 0;
    while (grants < 6 && cyc < 60) begin
      #1;
      if (m0_gnt || m1_gnt) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        exp_win = 1'b0;
`else
        exp_win = (grants % 2) == 1;
`endif
        checks++;
        if ({m1_gnt, m0_gnt} !== (exp_win ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL rr_grant #%0d gnt=%b%b, required m%0d", grants, m1_gnt, m0_gnt, exp_win);
        end
        sb.push_back('{exp_win, 1'b0, 32'hABADBEEF});
        grants++;
      end
      if (grants < 6) begin
        @(negedge clk); cyc++;
      end
    end
    @(posedge clk); #1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    checks++;
    if (grants != 6) begin
      errors++;
      $display("FAIL rr_timeout grants=%0d, required 6", grants);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_errors;
    int sc;
    sc = str_cnt;
    issue(1'b0, 1'b1, 2'b00, 12'h011, 32'h11111111, 1'b1, 32'h0);
    issue(1'b0, 1'b1, 2'b10, 12'h013, 32'h00002222, 1'b1, 32'h0);
    issue(1'b0, 1'b1, 2'b11, 12'h000, 32'h33333333, 1'b1, 32'h0);
    issue(1'b0, 1'b0, 2'b11, 12'h010, 32'h0, 1'b1, 32'h0);
    checks++;
    if (str_cnt != sc) begin
      errors++;
      $display("FAIL err_no_write strobes=%0d, required 0", str_cnt - sc);
    end
    issue(1'b0, 1'b0, 2'b00, 12'h010, 32'h0, 1'b0, 32'hABADBEEF);
    issue(1'b1, 1'b1, 2'b01, 12'h001, 32'h0000005A, 1'b0, 32'h0);
    issue(1'b1, 1'b0, 2'b01, 12'h001, 32'h0, 1'b0, 32'h0000005A);
  endtask

  task automatic test_withdraw;
    int n, sc;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 2'b10, 12'h010, '0);
    #1;
    n = 0;
    while (m1_gnt !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    sb.push_back('{1'b1, 1'b0, 32'h0000BEEF});
    @(posedge clk); #1;
    m1_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sc = str_cnt;
    drive(1'b0, 1'b1, 1'b1, 2'b00, 12'h010, 32'hFFFFFFFF);
    #1;
    checks++;
    if (m0_gnt !== 1'b0 || m1_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL withdraw_resp m0_gnt=%b m1_rvalid=%b, required 0 and 1", m0_gnt, m1_rvalid);
    end
    #2;
    m0_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (m0_gnt !== 1'b0 || mem_str !== 1'b0 || mem_addr !== '0) begin
        errors++;
        $display("FAIL withdraw_idle m0_gnt=%b mem_str=%b mem_addr=%h, required 0 0 000", m0_gnt, mem_str, mem_addr);
      end
    end
    checks++;
    if (str_cnt != sc) begin
      errors++;
      $display("FAIL withdraw_write strobes=%0d, required 0", str_cnt - sc);
    end
  endtask

  task automatic test_reset_mid;
    int n, sc;
    sc = str_cnt;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 2'b00, 12'h010, 32'h12345678);
    #1;
    n = 0;
    while (m1_gnt !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    @(posedge clk); #1;
    m1_req = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_str !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_access mem_str=%b, required 1", mem_str);
    end
    #1;
    clr_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 2'b00, 12'h010, '0);
    drive(1'b1, 1'b1, 1'b0, 2'b00, 12'h010, '0);
    #1;
    checks++;
    if ({m0_gnt, m0_rvalid, m0_rdata, m0_err, m1_gnt, m1_rvalid, m1_rdata, m1_err,
         mem_str, mem_mode, mem_addr, mem_din} !== '0) begin
      errors++;
      $display("FAIL rst_async gnt=%b%b str=%b addr=%h din=%h, required all zero",
               m1_gnt, m0_gnt, mem_str, mem_addr, mem_din);
    end
    @(negedge clk);
    checks++;
    if (m1_rvalid !== 1'b0 || str_cnt != sc) begin
      errors++;
      $display("FAIL rst_dropped m1_rvalid=%b strobes=%0d, required 0 and 0", m1_rvalid, str_cnt - sc);
    end
    #1;
    clr_n = 1'b1;
    #1;
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL rst_first_tie gnt=%b%b, required m0", m1_gnt, m0_gnt);
    end
    sb.push_back('{1'b0, 1'b0, 32'hABADBEEF});
    @(posedge clk); #1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    m0_req = 1'b0; m0_we = 1'b0; m0_mode = 2'b00; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_mode = 2'b00; m1_addr = '0; m1_wdata = '0;
    test_reset();
    test_store_load();
    test_back_to_back();
    test_errors();
    test_withdraw();
    test_reset_mid();
    issue(1'b0, 1'b0, 2'b00, 12'h010, 32'h0, 1'b0, 32'hABADBEEF);
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain outstanding=%0d, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the byte/half/word data memory's main access port (str, mode, address, data_in, data_out).
- Requester 0 is the CPU load/store unit; requester 1 is the debug/loader port.
- Grants one request at a time round-robin, rejects misaligned or illegal accesses, and returns a registered response.
- The memory's extra read port is not touched by this block.

Parameters:
AWIDTH, 12, byte address width (matches memory)
DWIDTH, 32, data width

Ports:
clk  in  1  clock, rising edge
clr_n  in  1  asynchronous active-low reset
m0_req  in  1  requester 0 request valid; held until m0_gnt
m0_we  in  1  1 = store, 0 = load
m0_mode  in  2  00 word, 01 byte, 10 half, 11 illegal
m0_addr  in  AWIDTH  byte address
m0_wdata  in  DWIDTH  store data, right-aligned
m0_gnt  out  1  request accepted this cycle
m0_rvalid  out  1  one-cycle response strobe
m0_rdata  out  DWIDTH  load data, right-aligned; 0 for stores and errors
m0_err  out  1  qualifies m0_rvalid; access rejected
m1_req, m1_we, m1_mode, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err  same as m0_*, for requester 1
mem_str  out  1  memory write strobe
mem_mode  out  2  memory access mode
mem_addr  out  AWIDTH  memory address
mem_din  out  DWIDTH  memory write data
mem_dout  in  DWIDTH  memory read data (combinational from mem_addr)

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - If any mN_req is high, select a winner and assert that requester's mN_gnt combinationally this cycle.
  - At the clock edge: latch we, mode, addr, wdata, winner id and err flag; go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - mem_mode, mem_addr and mem_din driven from the latched registers.
  - mem_str = latched_we & ~latched_err.
  - At the edge: rdata_reg <= (load & ~err) ? mem_dout : 0; go to RESP.
- RESP:
  - Winner's mN_rvalid = 1 for exactly one cycle, with mN_rdata = rdata_reg and mN_err = latched_err.
  - Go to IDLE. New requests are not granted in RESP.
- Latency and throughput: gnt in cycle T, memory access in T+1, rvalid in T+2. One access per 3 cycles.
- Outside ACCESS: mem_str = 0 and mem_mode/mem_addr/mem_din = 0.
- Outside RESP: all mN_rvalid, mN_rdata and mN_err = 0.
- mN_gnt is 0 outside IDLE.
- Round-robin:
  - last register holds the id of the most recent winner.
  - With both requesting, grant the requester that is not last.
  - With a single request, grant it regardless of last.
  - last updates on each grant; reset value is 1, so m0 wins the first tie.
- Error (err) is set when any of these holds:
  - mode = 11
  - mode = 00 and addr[1:0] != 0
  - mode = 10 and addr[0] = 1
  - An erroring store never asserts mem_str.
- Width rules: the memory performs lane shifting, so wdata and rdata pass through unmodified. Bits above the access width in rdata are whatever the memory returns (zero for byte/half).
- Reset:
  - clr_n low forces IDLE, last = 1 and every output to 0 immediately, independent of clk.
  - A transaction in flight is dropped with no rvalid. A store whose ACCESS edge has not yet occurred is not written.
- Requesters must hold req and fields stable until gnt. Dropping req before gnt withdraws the request with no side effects.

Optional Feature:
- Macro: DMEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, m0 always wins ties; the last register is removed.
- Undefined: round-robin as above.

Decomposition:
- Shared package dmem_pkg holds:
  - mode constants MODE_WORD = 2'b00, MODE_BYTE = 2'b01, MODE_HALF = 2'b10
  - state encoding IDLE/ACCESS/RESP
  - a request struct {we, mode, addr, wdata}
- Sub-module dmem_align_chk: combinational mode + addr -> err. Instantiated once, on the selected request.

Test Plan:
- m0 store word 0xDEADBEEF @0x010, then load word @0x010:
  - m0_gnt at T, mem_str = 1 at T+1, m0_rvalid at T+2 with rdata = 0
  - Load returns 0xDEADBEEF with err = 0.
- m1 store byte 0xAB @0x013, then load word @0x010:
  - Word load returns 0xABADBEEF.
  - Half load @0x012 returns 0x0000ABAD.
- m0 and m1 request continuously for 6 grants:
  - Grants alternate m0, m1, m0, m1, ...
  - With DMEM_ARB_FIXED_PRIO_EN, all 6 grants go to m0.
- m0 word store @0x011, half store @0x013, then mode 11 @0x000:
  - Each gets rvalid with err = 1 and mem_str never asserted.
  - Subsequent load @0x010 is unchanged.
- clr_n pulsed low during ACCESS of an m1 store:
  - Outputs go 0 immediately, no m1_rvalid, memory not written.
  - After release, m0 wins the first tie.
- m0_req raised then dropped while m1's transaction is in RESP:
  - No m0_gnt, no memory access for m0.
